// File: rtl/fp_op_sequencer_if.sv
// Request, arithmetic-unit and result handshake bundle for fp_op_sequencer.
// master = the sequencer, slave = its environment (producer, arithmetic top, consumer).
interface fp_op_sequencer_if;
  logic               in_valid;
  logic               in_ready;
  logic [1:0]         in_opcode;
  logic signed [31:0] in_a;
  logic signed [31:0] in_b;
  logic               op_start;
  logic [1:0]         op_opcode;
  logic signed [31:0] op_a;
  logic signed [31:0] op_b;
  logic signed [31:0] op_result;
  logic               op_done;
  logic               out_valid;
  logic               out_ready;
  logic signed [31:0] out_result;
  logic [1:0]         out_opcode;
  logic               out_err;

  modport master (
    input  in_valid, in_opcode, in_a, in_b, op_result, op_done, out_ready,
    output in_ready, op_start, op_opcode, op_a, op_b, out_valid, out_result, out_opcode, out_err
  );

  modport slave (
    output in_valid, in_opcode, in_a, in_b, op_result, op_done, out_ready,
    input  in_ready, op_start, op_opcode, op_a, op_b, out_valid, out_result, out_opcode, out_err
  );
endinterface

// File: rtl/fp_op_sequencer.sv
// Command sequencer in front of the Q9.23 add/mul/div top: request FIFO, one op in flight, result register.
// Optional macro FP_OP_SEQUENCER_STATS_EN adds saturating stat_ops / stat_errs counters.
module fp_op_sequencer #(
  parameter int DEPTH    = 4,
  parameter int TIMEOUT  = 64,
  parameter int MIN_WAIT = 2
) (
  input  logic clk,
  input  logic rst,
  fp_op_sequencer_if.master bus
`ifdef FP_OP_SEQUENCER_STATS_EN
  ,
  output logic [15:0] stat_ops,
  output logic [15:0] stat_errs
`endif
);
  localparam int DATA_W = 32;
  localparam int AW     = $clog2(DEPTH);
  localparam int CW     = $clog2(TIMEOUT + 1);
  localparam logic [AW:0]   DEPTH_C   = (AW + 1)'(DEPTH);
  localparam logic [CW-1:0] MIN_C     = CW'(MIN_WAIT);
  localparam logic [CW-1:0] TO_LAST_C = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, HOLD} state_e;

  typedef struct packed {
    logic [1:0]               opcode;
    logic signed [DATA_W-1:0] a;
    logic signed [DATA_W-1:0] b;
  } req_t;

  req_t                     mem_q [DEPTH];
  logic [AW-1:0]            wr_ptr_q, rd_ptr_q;
  logic [AW:0]              count_q, count_d;
  state_e                   state_q;
  logic [CW-1:0]            wcnt_q;
  logic                     op_start_q;
  logic [1:0]               op_opcode_q;
  logic signed [DATA_W-1:0] op_a_q, op_b_q;
  logic                     out_valid_q;
  logic signed [DATA_W-1:0] out_result_q;
  logic [1:0]               out_opcode_q;
  logic                     out_err_q;
  logic                     push, pop;
  req_t                     head;

  assign bus.in_ready   = (count_q != DEPTH_C);
  assign bus.op_start   = op_start_q;
  assign bus.op_opcode  = op_opcode_q;
  assign bus.op_a       = op_a_q;
  assign bus.op_b       = op_b_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_result = out_result_q;
  assign bus.out_opcode = out_opcode_q;
  assign bus.out_err    = out_err_q;

  always_comb begin
    push    = bus.in_valid && bus.in_ready;
    pop     = (state_q == IDLE) && (count_q != '0) && !out_valid_q;
    head    = mem_q[rd_ptr_q];
    count_d = count_q;
    if (push && !pop)
      count_d = count_q + (AW + 1)'(1);
    else if (pop && !push)
      count_d = count_q - (AW + 1)'(1);
  end

  // Queue storage carries data only; validity is tracked by count_q.
  always_ff @(posedge clk) begin
    if (push)
      mem_q[wr_ptr_q] <= '{opcode: bus.in_opcode, a: bus.in_a, b: bus.in_b};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push)
        wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)
        rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      wcnt_q       <= '0;
      op_start_q   <= 1'b0;
      op_opcode_q  <= '0;
      op_a_q       <= '0;
      op_b_q       <= '0;
      out_valid_q  <= 1'b0;
      out_result_q <= '0;
      out_opcode_q <= '0;
      out_err_q    <= 1'b0;
    end else begin
      op_start_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (pop) begin
            op_opcode_q <= head.opcode;
            op_a_q      <= head.a;
            op_b_q      <= head.b;
            // Reserved opcode never reaches the arithmetic top.
            if (head.opcode == 2'b11) begin
              out_result_q <= '0;
              out_opcode_q <= 2'b11;
              out_err_q    <= 1'b1;
              out_valid_q  <= 1'b1;
              state_q      <= HOLD;
            end else begin
              op_start_q <= 1'b1;
              state_q    <= ISSUE;
            end
          end
        end
        ISSUE: begin
          wcnt_q  <= '0;
          state_q <= WAIT;
        end
        WAIT: begin
          wcnt_q <= wcnt_q + CW'(1);
          // A done seen before MIN_WAIT may be left over from the previous op.
          if ((wcnt_q >= MIN_C) && bus.op_done) begin
            out_result_q <= bus.op_result;
            out_opcode_q <= op_opcode_q;
            out_err_q    <= 1'b0;
            out_valid_q  <= 1'b1;
            state_q      <= HOLD;
          end else if (wcnt_q == TO_LAST_C) begin
            out_result_q <= '0;
            out_opcode_q <= op_opcode_q;
            out_err_q    <= 1'b1;
            out_valid_q  <= 1'b1;
            state_q      <= HOLD;
          end
        end
        HOLD: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef FP_OP_SEQUENCER_STATS_EN
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic [15:0] stat_ops_q, stat_errs_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_ops_q  <= '0;
      stat_errs_q <= '0;
    end else if ((state_q == HOLD) && bus.out_ready) begin
      if (out_err_q)
        stat_errs_q <= sat_inc(stat_errs_q);
      else
        stat_ops_q <= sat_inc(stat_ops_q);
    end
  end

  assign stat_ops  = stat_ops_q;
  assign stat_errs = stat_errs_q;
`endif
endmodule

// File: tb/tb_fp_op_sequencer.sv
// Directed bench for fp_op_sequencer with a behavioural arithmetic-top model driven on the falling edge.
module tb_fp_op_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fp_op_sequencer_if bus();

`ifdef FP_OP_SEQUENCER_STATS_EN
  logic [15:0] stat_ops, stat_errs;
  fp_op_sequencer #(.DEPTH(4), .TIMEOUT(64), .MIN_WAIT(2)) dut (
    .clk(clk), .rst(rst), .bus(bus), .stat_ops(stat_ops), .stat_errs(stat_errs));
`else
  fp_op_sequencer #(.DEPTH(4), .TIMEOUT(64), .MIN_WAIT(2)) dut (
    .clk(clk), .rst(rst), .bus(bus));
`endif

  int checks = 0;
  int errors = 0;
  int start_cnt = 0;
  bit hang_div = 1'b0;
  bit stale_mode = 1'b0;
  int m_cnt = 0;
  bit m_busy = 1'b0;

  function automatic logic [31:0] arith(input logic [1:0] op, input logic signed [31:0] a,
                                        input logic signed [31:0] b);
    logic signed [63:0] ax, bx, p;
    ax = a;
    bx = b;
    case (op)
      2'b00:   return a + b;
      2'b01:   begin p = ax * bx; return p[54:23]; end
      default: begin
        if (b == 0) return 32'h0;
        p = (ax <<< 23) / bx;
        return p[31:0];
      end
    endcase
  endfunction

  // Arithmetic top model: done 3 cycles after start, held until the next start.
  always @(negedge clk) begin
    if (rst) begin
      bus.op_done   = 1'b0;
      bus.op_result = 32'h0;
      m_busy        = 1'b0;
    end else if (bus.op_start) begin
      start_cnt++;
      m_cnt  = 0;
      m_busy = !(hang_div && bus.op_opcode == 2'b10);
      if (stale_mode) begin
        bus.op_done   = 1'b1;
        bus.op_result = 32'hDEAD_BEEF;
      end else begin
        bus.op_done = 1'b0;
      end
    end else if (m_busy) begin
      m_cnt++;
      if (m_cnt == 3) begin
        bus.op_done   = 1'b1;
        bus.op_result = arith(bus.op_opcode, bus.op_a, bus.op_b);
        m_busy        = 1'b0;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    int guard;
    guard = 0;
    bus.in_valid  = 1'b1;
    bus.in_opcode = op;
    bus.in_a      = a;
    bus.in_b      = b;
    while (!bus.in_ready && guard < 500) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 500) begin
      checks++;
      errors++;
      $error("FAIL push: in_ready stayed low for %0d cycles, required 1", guard);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_out(output int n);
    n = 0;
    while (!bus.out_valid && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!bus.out_valid) begin
      checks++;
      errors++;
      $error("FAIL wait_out: out_valid=0 after %0d cycles, required 1", n);
    end
  endtask

  task automatic consume();
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int n, s0;
    bit seen;
    logic [31:0] exp_q[$];

    bus.in_valid  = 1'b0;
    bus.in_opcode = 2'b00;
    bus.in_a      = 32'h0;
    bus.in_b      = 32'h0;
    bus.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_in_ready",   32'(bus.in_ready),   32'd1);
    check("rst_out_valid",  32'(bus.out_valid),  32'd0);
    check("rst_op_start",   32'(bus.op_start),   32'd0);
    check("rst_out_result", bus.out_result,      32'd0);
    check("rst_out_err",    32'(bus.out_err),    32'd0);
    check("rst_op_a",       bus.op_a,            32'd0);
    rst = 1'b0;
    @(negedge clk);

    // 1.0 + 2.0 on an empty queue: six cycles from presenting the request.
    s0 = start_cnt;
    push(2'b00, 32'h0080_0000, 32'h0100_0000);
    wait_out(n);
    check("add_latency",    32'(n),                 32'd5);
    check("add_starts",     32'(start_cnt - s0),    32'd1);
    check("add_result",     bus.out_result,         32'h0180_0000);
    check("add_opcode",     32'(bus.out_opcode),    32'd0);
    check("add_err",        32'(bus.out_err),       32'd0);
    repeat (2) @(negedge clk);
    check("hold_valid",     32'(bus.out_valid),     32'd1);
    check("hold_op_a",      bus.op_a,               32'h0080_0000);
    consume();
    check("add_released",   32'(bus.out_valid),     32'd0);

    // Done stuck high: 1.5 * 3.0 must be taken at WAIT count 2, not the stale value.
    stale_mode = 1'b1;
    push(2'b01, 32'h00C0_0000, 32'h0180_0000);
    wait_out(n);
    check("stale_latency",  32'(n),                 32'd5);
    check("stale_result",   bus.out_result,         32'h0240_0000);
    check("stale_opcode",   32'(bus.out_opcode),    32'd1);
    consume();
    stale_mode = 1'b0;

    // Reserved opcode bypasses the arithmetic top.
    s0 = start_cnt;
    push(2'b11, 32'h1234_5678, 32'h0ABC_DEF0);
    wait_out(n);
    check("rsv_latency",    32'(n),                 32'd1);
    check("rsv_starts",     32'(start_cnt - s0),    32'd0);
    check("rsv_err",        32'(bus.out_err),       32'd1);
    check("rsv_opcode",     32'(bus.out_opcode),    32'd3);
    check("rsv_result",     bus.out_result,         32'd0);
    consume();

    // Fill with consumer stalled: one in flight, four queued.
    for (int i = 1; i <= 5; i++) begin
      push(2'b00, 32'(i) << 23, 32'h0080_0000);
      exp_q.push_back(32'(i + 1) << 23);
    end
    check("fill_full",      32'(bus.in_ready),      32'd0);
    repeat (10) @(negedge clk);
    check("fill_still_full", 32'(bus.in_ready),     32'd0);
    check("fill_head_held", bus.out_result,         32'h0100_0000);
    bus.out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      wait_out(n);
      check($sformatf("fill_result_%0d", k), bus.out_result, exp_q[k]);
      @(negedge clk);
    end
    bus.out_ready = 1'b0;
    check("fill_drained",   32'(bus.in_ready),      32'd1);

    // Divide that never completes, followed by a normal add.
    hang_div = 1'b1;
    push(2'b10, 32'h0100_0000, 32'h0080_0000);
    push(2'b00, 32'h0100_0000, 32'h0100_0000);
    wait_out(n);
    check("to_latency",     32'(n),                 32'd65);
    check("to_err",         32'(bus.out_err),       32'd1);
    check("to_result",      bus.out_result,         32'd0);
    check("to_opcode",      32'(bus.out_opcode),    32'd2);
    consume();
    wait_out(n);
    check("after_to_result", bus.out_result,        32'h0200_0000);
    check("after_to_err",   32'(bus.out_err),       32'd0);
    consume();

    // Reset with one op hung in WAIT and two entries queued.
    push(2'b10, 32'h0100_0000, 32'h0080_0000);
    push(2'b00, 32'h0080_0000, 32'h0080_0000);
    push(2'b00, 32'h0100_0000, 32'h0080_0000);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_in_ready",   32'(bus.in_ready),   32'd1);
    check("mid_rst_out_valid",  32'(bus.out_valid),  32'd0);
    check("mid_rst_op_start",   32'(bus.op_start),   32'd0);
    check("mid_rst_op_opcode",  32'(bus.op_opcode),  32'd0);
    check("mid_rst_op_a",       bus.op_a,            32'd0);
    check("mid_rst_op_b",       bus.op_b,            32'd0);
    check("mid_rst_out_result", bus.out_result,      32'd0);
    check("mid_rst_out_opcode", 32'(bus.out_opcode), 32'd0);
    check("mid_rst_out_err",    32'(bus.out_err),    32'd0);
    rst = 1'b0;
    hang_div = 1'b0;
    s0 = start_cnt;
    seen = 1'b0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.out_valid) seen = 1'b1;
    end
    bus.out_ready = 1'b0;
    check("post_rst_no_result", 32'(seen),             32'd0);
    check("post_rst_no_start",  32'(start_cnt - s0),   32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
